// File: rtl/joystick_adc_reader.sv
// Framed SPI transaction engine for an MCP3002-style dual-channel 10-bit ADC.
// Alternately converts X (ch0) and Y (ch1) and publishes registered results.
module joystick_adc_reader #(
    parameter int CLK_DIV    = 16,
    parameter int IDLE_TICKS = 4
) (
    input  logic       fastClock,
    input  logic       reset,
    input  logic       enable,
    input  logic       adcDout,
    output logic       adcCsN,
    output logic       adcSclk,
    output logic       adcDin,
    output logic [9:0] xValue,
    output logic [9:0] yValue,
    output logic [3:0] xNibble,
    output logic [3:0] yNibble,
    output logic       sampleValid,
    output logic       sampleChannel
);

    localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam int GAP_W = (IDLE_TICKS > 1) ? $clog2(IDLE_TICKS + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_HIGH,
        ST_LOW
    } state_t;

    state_t           state_q;
    logic [DIV_W-1:0] div_q;
    logic [GAP_W-1:0] gap_q;
    logic [3:0]       pulse_q;
    logic [3:0]       pulse_d;
    logic [9:0]       shift_q;
    logic [9:0]       result_d;
    logic             chan_q;
    logic             din_d;
    logic             tick;
    logic             csn_q;
    logic             sclk_q;
    logic             din_q;
    logic [9:0]       x_q;
    logic [9:0]       y_q;
    logic             valid_q;
    logic             schan_q;

    always_comb begin
        tick     = (div_q == DIV_W'(CLK_DIV - 1));
        pulse_d  = pulse_q + 4'd1;
        result_d = {shift_q[8:0], adcDout};
        // Command bits for the pulse about to be clocked: SGL, ODD, MSBF, then zeros.
        case (pulse_d)
            4'd2:    din_d = 1'b1;
            4'd3:    din_d = chan_q;
            4'd4:    din_d = 1'b1;
            default: din_d = 1'b0;
        endcase
    end

    always_ff @(posedge fastClock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            gap_q   <= '0;
            pulse_q <= '0;
            shift_q <= '0;
            chan_q  <= 1'b0;
            csn_q   <= 1'b1;
            sclk_q  <= 1'b0;
            din_q   <= 1'b0;
            x_q     <= 10'h200;
            y_q     <= 10'h200;
            valid_q <= 1'b0;
            schan_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (tick) div_q <= '0;
            else      div_q <= div_q + 1'b1;

            if (tick) begin
                case (state_q)
                    ST_IDLE: begin
                        if (gap_q != GAP_W'(IDLE_TICKS)) begin
                            gap_q <= gap_q + 1'b1;
                        end else if (enable) begin
                            csn_q   <= 1'b0;
                            din_q   <= 1'b1;
                            pulse_q <= 4'd1;
                            state_q <= ST_SETUP;
                        end
                    end
                    ST_SETUP: begin
                        sclk_q  <= 1'b1;
                        state_q <= ST_HIGH;
                    end
                    ST_HIGH: begin
                        sclk_q <= 1'b0;
                        // Pulse 5 is the null bit; data bits arrive on pulses 6..15.
                        if (pulse_q >= 4'd6) shift_q <= result_d;
                        if (pulse_q == 4'd15) begin
                            csn_q <= 1'b1;
                            din_q <= 1'b0;
                            if (chan_q) y_q <= result_d;
                            else        x_q <= result_d;
                            valid_q <= 1'b1;
                            schan_q <= chan_q;
                            chan_q  <= ~chan_q;
                            gap_q   <= '0;
                            state_q <= ST_IDLE;
                        end else begin
                            pulse_q <= pulse_d;
                            din_q   <= din_d;
                            state_q <= ST_LOW;
                        end
                    end
                    ST_LOW: begin
                        sclk_q  <= 1'b1;
                        state_q <= ST_HIGH;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign adcCsN        = csn_q;
    assign adcSclk       = sclk_q;
    assign adcDin        = din_q;
    assign xValue        = x_q;
    assign yValue        = y_q;
    assign xNibble       = x_q[9:6];
    assign yNibble       = y_q[9:6];
    assign sampleValid   = valid_q;
    assign sampleChannel = schan_q;

endmodule

// File: doc/joystick_adc_reader.md
Name: joystick_adc_reader

Overview:
- Serial-ADC front end for one player's analog stick.
- Drives a dual-channel 10-bit SPI-style ADC (MCP3002-compatible framing) and alternately converts channel 0 (X) and channel 1 (Y).
- Publishes registered 10-bit results, plus the 4-bit MSB nibbles that feed the controller manager's X/Y GPIO half-word inputs (bits 7:4 and 15:12).
- Replaces the free-running ADC slow clock with a framed, chip-selected transaction engine.

Parameters:
- CLK_DIV, 16: fastClock cycles per SCLK half-period. Minimum 2.
- IDLE_TICKS, 4: half-period ticks with adcCsN high between frames. Minimum 1.

Ports:
- fastClock  input  1  system clock; all logic is on its rising edge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  permits new frames to start.
- adcDout  input  1  ADC serial data out (MISO).
- adcCsN  output  1  ADC chip select, active low.
- adcSclk  output  1  ADC serial clock.
- adcDin  output  1  ADC serial data in (MOSI).
- xValue  output  10  last X conversion.
- yValue  output  10  last Y conversion.
- xNibble  output  4  xValue[9:6].
- yNibble  output  4  yValue[9:6].
- sampleValid  output  1  one-cycle pulse when xValue or yValue updates.
- sampleChannel  output  1  channel of the latest update (0 = X, 1 = Y). Valid with sampleValid and held afterwards.

Behaviour:
- Reset values:
  - adcCsN=1, adcSclk=0, adcDin=0, sampleValid=0, sampleChannel=0.
  - xValue=yValue=10'h200 (stick centred; nibble 4'b1000, so neither tilt decode fires).
  - Divider=0, state=IDLE, gap counter=0, next channel=0.
- Tick: the divider counts 0..CLK_DIV-1 and wraps. tick=1 in the cycle where divider==CLK_DIV-1. All state changes below happen only on tick cycles, except the sampleValid clear.
- States: IDLE, SETUP, HIGH, LOW.
- IDLE:
  - adcCsN=1, adcSclk=0.
  - The gap counter increments per tick, saturating at IDLE_TICKS.
  - On a tick with gap==IDLE_TICKS and enable=1: adcCsN<=0, adcDin<=1 (start bit), pulse index<=1, go to SETUP.
- SETUP: on the next tick, adcSclk<=1 (rising edge of pulse 1), go to HIGH.
- HIGH:
  - On a tick, adcSclk<=0.
  - In the same cycle, if pulse index is 6..15, shift adcDout into the result register, MSB first. The ADC output is stable for the whole high half-period.
  - If pulse index==15: adcCsN<=1, adcDin<=0, and write the result (including the bit just shifted) to xValue or yValue according to the current channel. Set sampleValid<=1 and sampleChannel<=channel, toggle the channel, clear gap, go to IDLE.
  - Otherwise: increment pulse index, drive adcDin for the new index, go to LOW.
- LOW: on a tick, adcSclk<=1, go to HIGH.
- adcDin by pulse index:
  - 1 = start (1)
  - 2 = SGL (1)
  - 3 = ODD (channel)
  - 4 = MSBF (1)
  - 5..15 = 0
  - Pulse 5 is the ADC null bit and is not captured.
- sampleValid: high for exactly one fastClock cycle, cleared on the following cycle.
- Frame timing:
  - adcCsN is low for exactly 30 ticks (30*CLK_DIV cycles).
  - Exactly 15 SCLK rising edges per frame. The first rising edge occurs one tick after adcCsN falls.
  - Frame-to-frame period is 30 + IDLE_TICKS + 1 ticks.
- enable deasserted mid-frame: the current frame completes and its result is published. No new frame starts until enable=1. Channel order is preserved.
- reset mid-frame:
  - On the next edge, adcCsN=1, adcSclk=0, and the partial result is discarded.
  - Values return to 10'h200, the channel returns to X, and the full IDLE gap is observed before the next frame.
- Result registers are never partially visible; xValue and yValue change only on their publish cycle.

Test Plan:
- Reset then hold: with reset high for 3 cycles, then enable=0 for 1000 cycles, require adcCsN=1, adcSclk=0, xValue=yValue=10'h200, xNibble=yNibble=4'h8, and sampleValid never asserts.
- Single X frame, CLK_DIV=16: the ADC model returns 10'h3FF on ch0. Require:
  - adcDin on the 4 command rising edges = 1,1,0,1
  - adcCsN low for 480 cycles
  - 15 rising edges of adcSclk
  - xValue=10'h3FF, xNibble=4'hF
  - sampleValid one cycle with sampleChannel=0
- Alternation: the model returns ch0=10'h155 and ch1=10'h0AA. Require:
  - The second frame's command is 1,1,1,1.
  - yValue=10'h0AA, yNibble=4'h2.
  - The third frame targets X again.
  - Consecutive adcCsN falling edges are 35 ticks apart (560 cycles).
- Enable drop: deassert enable 5 ticks into a frame. Require that frame to publish normally, with no further adcCsN falling edge. Reassert enable and require the next frame to use the other channel.
- Reset mid-frame: assert reset at pulse index 10. On the next edge require adcCsN=1, adcSclk=0, xValue=10'h200 and no sampleValid. Require the first post-reset frame to be channel 0.
- Minimum divider, CLK_DIV=2, IDLE_TICKS=1: the model returns ch0 10'h001. Require xValue=10'h001 and adcCsN low for exactly 60 cycles.
